// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared defaults and register-count derivation for the busy scoreboard
package reg_scoreboard_pkg;
  localparam int ADDR_W_DEF = 5;
  localparam int RD_PORTS_DEF = 2;
  localparam int ZERO_REG = 0;
  function automatic int nreg(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/reg_scoreboard_decoder_onehot.sv
// decoder_onehot: enabled one-hot decode of a W-bit index into 2**W bits, all zero when disabled
module decoder_onehot #(
  parameter int W = 5
) (
  input  logic             en,
  input  logic [W-1:0]     sel,
  output logic [2**W-1:0]  onehot
);
  always_comb begin
    onehot = '0;
    onehot[sel] = en;
  end
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register busy tracking with RAW query ports and WAW issue stall; define REG_SCOREBOARD_ERR_EN for the sticky err detector
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_PORTS = RD_PORTS_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_valid,
  input  logic [ADDR_W-1:0]          issue_addr,
  output logic                       issue_ready,
  output logic                       stall,
  input  logic                       wb_valid,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [RD_PORTS*ADDR_W-1:0] rd_addr,
  output logic [RD_PORTS-1:0]        rd_busy,
  output logic [2**ADDR_W-1:0]       busy_vec,
  output logic [ADDR_W-1:0]          busy_cnt,
  output logic                       err
);
  localparam int NREG = nreg(ADDR_W);
  logic [NREG-1:0] busy_q, busy_d, set_mask, clr_mask;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic wb_bypass, set_en, clr_en, eff_set, eff_clr;
  // Register 0 never becomes busy, so busy_q[0] is 0 and it always reads as ready.
  always_comb begin
    wb_bypass = wb_valid & (wb_addr == issue_addr);
    issue_ready = ~busy_q[issue_addr] | wb_bypass;
    stall = issue_valid & ~issue_ready;
    set_en = issue_valid & issue_ready & (issue_addr != ADDR_W'(ZERO_REG));
    clr_en = wb_valid & (wb_addr != ADDR_W'(ZERO_REG));
    eff_set = set_en & ~busy_q[issue_addr];
    eff_clr = clr_en & busy_q[wb_addr] & ~(set_en & wb_bypass);
    busy_d = (busy_q & ~clr_mask) | set_mask;
    cnt_d = (eff_set == eff_clr) ? cnt_q : eff_set ? cnt_q + ADDR_W'(1) : cnt_q - ADDR_W'(1);
  end
  decoder_onehot #(.W(ADDR_W)) u_set (.en(set_en), .sel(issue_addr), .onehot(set_mask));
  decoder_onehot #(.W(ADDR_W)) u_clr (.en(clr_en), .sel(wb_addr), .onehot(clr_mask));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q <= cnt_d;
    end
  end
  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[i*ADDR_W +: ADDR_W];
    assign rd_busy[i] = busy_q[a] & ~(wb_valid & (wb_addr == a)) & (a != ADDR_W'(ZERO_REG));
  end
  assign busy_vec = busy_q;
  assign busy_cnt = cnt_q;
`ifdef REG_SCOREBOARD_ERR_EN
  logic err_q, err_d;
  always_comb err_d = err_q | (clr_en & ~busy_q[wb_addr]) |
                      (set_en & busy_q[issue_addr] & (cnt_q == ADDR_W'(NREG-1)));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed stimulus pushes expected responses; a negedge monitor pops and compares
module tb_reg_scoreboard;
  localparam logic ERRV =
`ifdef REG_SCOREBOARD_ERR_EN
    1'b1;
`else
    1'b0;
`endif
  typedef struct {
    string       nm;
    logic [31:0] bv;
    logic [4:0]  cnt;
    logic        err;
    logic        rdy;
    logic        stl;
    logic [1:0]  rdb;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic issue_valid = 1'b0, wb_valid = 1'b0;
  logic [4:0] issue_addr = '0, wb_addr = '0;
  logic [9:0] rd_addr = '0;
  logic issue_ready, stall, err;
  logic [1:0] rd_busy;
  logic [31:0] busy_vec;
  logic [4:0] busy_cnt;
  exp_t q[$];
  int checks = 0, failures = 0;

  reg_scoreboard #(.ADDR_W(5), .RD_PORTS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready), .stall(stall),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .rd_addr(rd_addr), .rd_busy(rd_busy),
    .busy_vec(busy_vec), .busy_cnt(busy_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=0x%0h expected=0x%0h", nm, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "busy_vec", busy_vec, e.bv);
      chk(e.nm, "busy_cnt", 32'(busy_cnt), 32'(e.cnt));
      chk(e.nm, "err", 32'(err), 32'(e.err));
      chk(e.nm, "issue_ready", 32'(issue_ready), 32'(e.rdy));
      chk(e.nm, "stall", 32'(stall), 32'(e.stl));
      chk(e.nm, "rd_busy", 32'(rd_busy), 32'(e.rdb));
    end
  end

  task automatic drive(input logic iv, input logic [4:0] ia, input logic wv, input logic [4:0] wa,
                       input logic [4:0] r0, input logic [4:0] r1);
    issue_valid = iv; issue_addr = ia; wb_valid = wv; wb_addr = wa; rd_addr = {r1, r0};
  endtask

  task automatic expect_cyc(input string nm, input logic [31:0] bv, input logic [4:0] cnt, input logic e,
                            input logic rdy, input logic stl, input logic [1:0] rdb);
    exp_t x;
    x.nm = nm; x.bv = bv; x.cnt = cnt; x.err = e; x.rdy = rdy; x.stl = stl; x.rdb = rdb;
    q.push_back(x);
    @(posedge clk) #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk) #1;
    drive(1, 5, 0, 0, 5, 0);
    expect_cyc("in_reset", 32'h0, 0, 0, 1, 0, 2'b00);
    rst_n = 1'b1;
    drive(1, 5, 0, 0, 5, 0);
    expect_cyc("issue_r5", 32'h0, 0, 0, 1, 0, 2'b00);
    drive(0, 0, 0, 0, 5, 0);
    expect_cyc("r5_busy", 32'h20, 1, 0, 1, 0, 2'b01);
    drive(1, 5, 0, 0, 5, 0);
    expect_cyc("waw_stall", 32'h20, 1, 0, 0, 1, 2'b01);
    drive(1, 5, 1, 5, 5, 0);
    expect_cyc("wb_bypass_reissue", 32'h20, 1, 0, 1, 0, 2'b00);
    drive(1, 7, 0, 0, 5, 7);
    expect_cyc("issue_r7", 32'h20, 1, 0, 1, 0, 2'b01);
    drive(0, 0, 1, 7, 5, 7);
    expect_cyc("wb_r7_rd_bypass", 32'hA0, 2, 0, 1, 0, 2'b01);
    drive(0, 0, 0, 0, 5, 7);
    expect_cyc("r7_freed", 32'h20, 1, 0, 1, 0, 2'b01);
    drive(1, 0, 1, 0, 0, 0);
    expect_cyc("r0_issue_wb", 32'h20, 1, 0, 1, 0, 2'b00);
    drive(0, 0, 0, 0, 0, 5);
    expect_cyc("r0_no_effect", 32'h20, 1, 0, 1, 0, 2'b10);
    drive(0, 0, 1, 9, 9, 5);
    expect_cyc("wb_r9_idle", 32'h20, 1, 0, 1, 0, 2'b10);
    drive(0, 0, 0, 0, 9, 5);
    expect_cyc("err_after_wb_r9", 32'h20, 1, ERRV, 1, 0, 2'b10);
    drive(0, 0, 0, 0, 9, 5);
    expect_cyc("err_sticky", 32'h20, 1, ERRV, 1, 0, 2'b10);
    drive(0, 0, 1, 5, 5, 5);
    expect_cyc("wb_r5", 32'h20, 1, ERRV, 1, 0, 2'b00);
    drive(0, 0, 0, 0, 5, 5);
    expect_cyc("all_free", 32'h0, 0, ERRV, 1, 0, 2'b00);
    for (int k = 1; k < 32; k++) begin
      drive(1, 5'(k), 0, 0, 1, 0);
      expect_cyc($sformatf("fill_r%0d", k), (32'(1) << k) - 32'd2, 5'(k - 1), ERRV, 1, 0, {1'b0, k > 1});
    end
    drive(0, 0, 0, 0, 1, 31);
    expect_cyc("full_no_wrap", 32'hFFFF_FFFE, 31, ERRV, 1, 0, 2'b11);
    drive(1, 3, 0, 0, 1, 2);
    expect_cyc("full_stall_r3", 32'hFFFF_FFFE, 31, ERRV, 0, 1, 2'b11);
    drive(1, 3, 0, 0, 1, 2);
    rst_n = 1'b0;
    expect_cyc("async_reset", 32'h0, 0, 0, 1, 0, 2'b00);
    drive(1, 4, 0, 0, 4, 2);
    expect_cyc("held_reset", 32'h0, 0, 0, 1, 0, 2'b00);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 4, 3);
    expect_cyc("after_reset", 32'h0, 0, 0, 1, 0, 2'b00);
    @(negedge clk) #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Parametrised register-busy scoreboard for the pipelined datapath. It turns destination-register addresses into one-hot set and clear masks and holds a per-register busy vector. From that vector it answers source-operand hazard queries on several read ports and stalls a second issue to a register that is already being written (WAW). It sits between decode/issue and the register file, next to the write-enable decode path.

## Interface
Parameters:
- ADDR_W, 5, register address width; NREG = 2**ADDR_W registers
- RD_PORTS, 2, number of source-operand query ports

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  instruction with destination write is presented
- issue_addr  in  ADDR_W  destination register of issuing instruction
- issue_ready  out  1  issue may proceed (no WAW hazard)
- stall  out  1  issue_valid & ~issue_ready
- wb_valid  in  1  writeback completes this cycle
- wb_addr  in  ADDR_W  register being written back
- rd_addr  in  RD_PORTS*ADDR_W  packed source addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rd_busy  out  RD_PORTS  bit i set: source i has a pending write (RAW hazard)
- busy_vec  out  NREG  registered busy bits; bit 0 always 0
- busy_cnt  out  ADDR_W  number of busy registers (max NREG-1)
- err  out  1  sticky protocol error (see Configuration)

## Operation
- Set mask = one-hot decode of issue_addr, enabled by issue_valid & issue_ready & (issue_addr != 0).
- Clear mask = one-hot decode of wb_addr, enabled by wb_valid & (wb_addr != 0).
- busy_next = (busy & ~clear) | set. Set wins over clear on the same bit.
- Register 0 is hardwired: it is never busy, never stalls, and never sets rd_busy.
- issue_ready = ~busy[issue_addr] | (wb_valid & wb_addr == issue_addr). Writeback bypass: a reg freed this cycle may be reissued the same cycle, and stays busy.
- rd_busy[i] = busy[rd_addr_i] & ~(wb_valid & wb_addr == rd_addr_i) & (rd_addr_i != 0).
- busy_cnt: +1 on effective set only; -1 on effective clear only (bit was 1 and not re-set); unchanged when both hit the same reg or neither occurs. It never wraps, because at most NREG-1 regs can be busy.
- Writeback to a non-busy register: clear has no effect, busy_cnt is unchanged, and the error condition is raised.
- issue_valid with issue_ready low: no state change; upstream holds the request.

## Timing
- issue_ready, stall, rd_busy: combinational from current state and same-cycle inputs. There is no path from issue_* to rd_busy.
- busy_vec, busy_cnt, err: registered. An update is visible one cycle after the accepting edge.
- Issue-to-busy latency is 1 cycle. Writeback-to-free is 0 cycles for queries (bypass) and 1 cycle on busy_vec.
- Reset (asynchronous assert, at any time including mid-operation): busy_vec=0, busy_cnt=0, err=0. While reset is asserted, issue_ready=1 and rd_busy=0.

## Configuration
- REG_SCOREBOARD_ERR_EN defined: err is set on wb_valid to an address ≠0 whose busy bit is 0, or on an issue accepted while busy_cnt==NREG-1 and the reg is not free. err stays set until reset.
- Not defined: err is tied to 0 and the detection logic is not built. Functional behaviour is otherwise identical.

## Structure
- Shared package holds: ADDR_W default, NREG derivation, the RD_PORTS default, and a ZERO_REG constant (0).
- The natural sub-module is decoder_onehot, parametrised by input width W, with an enable input and an output of 2**W one-hot bits; output is all zero when disabled. It is instantiated twice (set and clear masks). Read-port lookups are muxes into busy_vec, not decoders.

## Test plan
- Reset, then issue r5 -> next cycle busy_vec=0x20, busy_cnt=1. rd_addr port0=5 gives rd_busy[0]=1.
- r5 busy, issue r5 again with no wb -> issue_ready=0, stall=1, state unchanged. In the same cycle assert wb r5 -> issue_ready=1, r5 stays busy, busy_cnt stays 1.
- r7 busy, wb r7 with rd_addr port1=7 in the same cycle -> rd_busy[1]=0 that cycle. busy_vec bit7=0 next cycle, busy_cnt decrements.
- Issue r0 and wb r0 -> issue_ready=1, busy_vec unchanged, busy_cnt unchanged, err stays 0.
- With the macro defined, wb r9 while r9 is not busy -> err=1 next cycle and stays 1. Without the macro, err stays 0.
- Issue r1..r31 on consecutive cycles -> busy_cnt=31 (no wrap). Assert rst_n low mid-sequence -> all outputs return to reset values immediately.
